// File: rtl/dcache_mem.sv
// dcache_mem: direct-mapped, write-back, write-allocate data cache.
// Hits complete in one cycle; misses stall the pipeline while the victim
// line is written back (if dirty) and the new line is refilled one word
// per req/ack beat.
// Optional build macro DCACHE_STATS_EN adds hit/miss counters.
module dcache_mem #(
   parameter int SETS           = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  be_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_count_o,
   output logic [31:0] miss_count_o
`endif
);
   localparam int BW  = $clog2(WORDS_PER_LINE);
   localparam int IDX = $clog2(SETS);
   localparam int OFF = BW + 2;
   localparam int TW  = 32 - OFF - IDX;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WB     = 2'd1;
   localparam logic [1:0] S_REFILL = 2'd2;

   // Storage: data and tags are never reset, only valid/dirty are.
   logic [31:0]      r_data [SETS*WORDS_PER_LINE];
   logic [TW-1:0]    r_tag  [SETS];
   logic [SETS-1:0]  r_valid;
   logic [SETS-1:0]  r_dirty;
   logic [1:0]       r_state;
   logic [BW-1:0]    r_beat;
   logic [31-OFF:0]  r_line;     // line address of the missing access

   logic [IDX-1:0]   w_idx;
   logic [TW-1:0]    w_tag;
   logic [BW-1:0]    w_word;
   logic             w_hit;
   logic             w_lookup;
   logic             w_miss;
   logic             w_store_hit;
   logic [IDX-1:0]   w_fidx;
   logic [TW-1:0]    w_ftag;
   logic             w_last;
   logic             w_refill_ack;
   logic             w_unused;

   assign w_idx    = addr_i[OFF+IDX-1:OFF];
   assign w_tag    = addr_i[31:OFF+IDX];
   assign w_word   = addr_i[OFF-1:2];
   assign w_unused = ^addr_i[1:0];
   assign w_fidx   = r_line[IDX-1:0];
   assign w_ftag   = r_line[31-OFF:IDX];
   assign w_last   = (r_beat == BW'(WORDS_PER_LINE - 1));

   // Lookup is only meaningful in IDLE; reset forces the access inactive so
   // stall_o and rdata_o fall immediately.
   assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_lookup     = (r_state == S_IDLE) && req_i && !rst_i;
   assign w_miss       = w_lookup && !w_hit;
   assign w_store_hit  = w_lookup && w_hit && we_i;
   assign w_refill_ack = (r_state == S_REFILL) && mem_ack_i;

   assign rdata_o     = (w_lookup && w_hit && !we_i) ? r_data[{w_idx, w_word}] : 32'd0;
   assign stall_o     = (r_state != S_IDLE) || w_miss;
   assign mem_req_o   = (r_state != S_IDLE);
   assign mem_we_o    = (r_state == S_WB);
   assign mem_addr_o  = (r_state == S_WB)     ? {r_tag[w_fidx], w_fidx, r_beat, 2'b00} :
                        (r_state == S_REFILL) ? {w_ftag, w_fidx, r_beat, 2'b00} : 32'd0;
   assign mem_wdata_o = (r_state == S_WB) ? r_data[{w_fidx, r_beat}] : 32'd0;

   // Miss sequencing and line status bits.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
         r_line  <= '0;
         r_valid <= '0;
         r_dirty <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_store_hit) begin
                  r_dirty[w_idx] <= 1'b1;
               end else if (w_miss) begin
                  r_line  <= addr_i[31:OFF];
                  r_beat  <= '0;
                  r_state <= (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_REFILL;
               end
            end
            S_WB: begin
               if (mem_ack_i) begin
                  r_beat <= w_last ? '0 : r_beat + 1'b1;
                  if (w_last) r_state <= S_REFILL;
               end
            end
            S_REFILL: begin
               if (mem_ack_i) begin
                  r_beat <= w_last ? '0 : r_beat + 1'b1;
                  if (w_last) begin
                     r_valid[w_fidx] <= 1'b1;
                     r_dirty[w_fidx] <= 1'b0;
                     r_state         <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Data/tag array writes: store-hit byte lanes or refill beats.
   always_ff @(posedge clk_i) begin
      if (w_store_hit) begin
         for (int i = 0; i < 4; i++) begin
            if (be_i[i]) r_data[{w_idx, w_word}][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
      if (w_refill_ack) begin
         r_data[{w_fidx, r_beat}] <= mem_rdata_i;
         if (w_last) r_tag[w_fidx] <= w_ftag;
      end
   end

`ifdef DCACHE_STATS_EN
   logic        r_relookup;
   logic [31:0] r_hit_count;
   logic [31:0] r_miss_count;

   assign hit_count_o  = r_hit_count;
   assign miss_count_o = r_miss_count;

   // Hit/miss counters; the hit that ends a fill is part of the miss.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_relookup   <= 1'b0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         r_relookup <= w_refill_ack && w_last;
         if (w_lookup && w_hit && !r_relookup) r_hit_count <= r_hit_count + 32'd1;
         if (w_miss) r_miss_count <= r_miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_mem.sv
// Testbench for dcache_mem: directed scenarios followed by random traffic,
// checked against a flat architectural memory plus a set-level hit model.
module tb_dcache_mem;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [3:0]  be_i;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count_o;
   logic [31:0] miss_count_o;
`endif

   always #5 clk_i = ~clk_i;

   dcache_mem dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req_i      (req_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .be_i       (be_i),
      .rdata_o    (rdata_o),
      .stall_o    (stall_o),
      .mem_req_o  (mem_req_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i),
      .mem_ack_i  (mem_ack_i)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count_o (hit_count_o),
      .miss_count_o(miss_count_o)
`endif
   );

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
   } beat_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] bmem [1024];   // backing memory behind the bus
   logic [31:0] amem [1024];   // architectural memory view
   logic [23:0] mtag [16];
   bit          mvalid [16];
   bit          mdirty [16];
   int          mhits = 0;
   int          mmisses = 0;
   beat_t       blog [$];
   int          ack_dly = 2;
   bit          rand_mode = 0;
   int          rcnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Memory responder: acks each beat ack_dly cycles after it appears.
   always @(negedge clk_i) begin
      mem_ack_i = 1'b0;
      if (mem_req_o && !rst_i) begin
         if (rcnt >= ack_dly) begin
            mem_ack_i = 1'b1;
            rcnt = 0;
            if (mem_we_o) begin
               bmem[mem_addr_o[11:2]] = mem_wdata_o;
               blog.push_back('{1'b1, mem_addr_o, mem_wdata_o});
            end else begin
               mem_rdata_i = bmem[mem_addr_o[11:2]];
               blog.push_back('{1'b0, mem_addr_o, mem_rdata_i});
            end
            ack_dly = rand_mode ? int'($urandom_range(0, 2)) : 2;
         end else begin
            rcnt++;
         end
      end else begin
         rcnt = 0;
      end
   end

   // One access: drive, wait out any stall, then check against the models.
   task automatic access(input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
      logic [3:0]  s;
      logic [23:0] t;
      int          widx;
      int          cyc;
      int          nw;
      int          nr;
      bit          exp_miss;
      logic [31:0] vbase;
      logic [31:0] ea;
      s        = addr[7:4];
      t        = addr[31:8];
      widx     = int'(addr[11:2]);
      exp_miss = !(mvalid[s] && mtag[s] == t);
      nw       = (exp_miss && mvalid[s] && mdirty[s]) ? 4 : 0;
      nr       = exp_miss ? 4 : 0;
      vbase    = {mtag[s], s, 4'h0};
      @(negedge clk_i);
      blog.delete();
      req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; be_i = be;
      #1;
      cyc = 0;
      while (stall_o && cyc < 300) begin
         @(negedge clk_i);
         #1;
         cyc++;
      end
      chk("stall_bounded", (cyc < 300) ? 32'd1 : 32'd0, 32'd1);
      chk("miss", (cyc > 0) ? 32'd1 : 32'd0, exp_miss ? 32'd1 : 32'd0);
      chk("nbeats", 32'(blog.size()), 32'(nw + nr));
      if (blog.size() == nw + nr) begin
         for (int i = 0; i < nw + nr; i++) begin
            ea = (i < nw) ? vbase + 32'(4 * i) : {addr[31:4], 4'h0} + 32'(4 * (i - nw));
            chk("beat_we", {31'd0, blog[i].we}, (i < nw) ? 32'd1 : 32'd0);
            chk("beat_addr", blog[i].addr, ea);
            if (i < nw) chk("wb_data", blog[i].data, amem[ea[11:2]]);
         end
      end
      if (exp_miss) begin
         mmisses++;
         mtag[s] = t; mvalid[s] = 1'b1; mdirty[s] = 1'b0;
      end else begin
         mhits++;
      end
      if (we) begin
         for (int b = 0; b < 4; b++) if (be[b]) amem[widx][8*b +: 8] = wd[8*b +: 8];
         mdirty[s] = 1'b1;
      end else begin
         chk("rdata", rdata_o, amem[widx]);
      end
   endtask

   task automatic check_stats();
`ifdef DCACHE_STATS_EN
      chk("hit_count", hit_count_o, 32'(mhits));
      chk("miss_count", miss_count_o, 32'(mmisses));
`endif
   endtask

   initial begin
      int          cyc;
      int          nwr;
      logic [31:0] a;
      rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      for (int i = 0; i < 1024; i++) begin
         amem[i] = $urandom;
         bmem[i] = amem[i];
      end
      for (int b = 0; b < 4; b++) begin
         amem[64 + b] = 32'hA0 + 32'(b);
         bmem[64 + b] = amem[64 + b];
      end
      for (int i = 0; i < 16; i++) begin
         mvalid[i] = 1'b0; mdirty[i] = 1'b0; mtag[i] = '0;
      end

      // Reset state
      repeat (3) @(negedge clk_i);
      #1;
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_mem_addr", mem_addr_o, 32'd0);
      chk("rst_mem_wdata", mem_wdata_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Cold load, store hit with byte enables, dirty eviction
      access(1'b0, 32'h100, 32'd0, 4'h0);
      chk("cold_rdata", rdata_o, 32'h000000A0);
      access(1'b1, 32'h104, 32'hDEADBEEF, 4'b0011);
      access(1'b0, 32'h104, 32'd0, 4'h0);
      chk("be_merge", rdata_o, 32'h0000BEEF);
      access(1'b0, 32'h900, 32'd0, 4'h0);
      if (blog.size() == 8) chk("wb_beef", blog[1].data, 32'h0000BEEF);

      // Clean eviction: read beats only
      access(1'b0, 32'h100, 32'd0, 4'h0);
      access(1'b0, 32'h900, 32'd0, 4'h0);
      nwr = 0;
      foreach (blog[i]) if (blog[i].we) nwr++;
      chk("clean_no_write", 32'(nwr), 32'd0);

      // Reset while beat 2 of a refill is pending
      @(negedge clk_i);
      blog.delete();
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100;
      cyc = 0;
      while (blog.size() < 2 && cyc < 100) begin
         @(negedge clk_i);
         #1;
         cyc++;
      end
      chk("reach_beat2", (cyc < 100) ? 32'd1 : 32'd0, 32'd1);
      @(posedge clk_i);
      #1;
      chk("pre_rst_req", {31'd0, mem_req_o}, 32'd1);
      rst_i = 1'b1;
      #1;
      chk("midrst_mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("midrst_stall", {31'd0, stall_o}, 32'd0);
      chk("midrst_rdata", rdata_o, 32'd0);
      @(negedge clk_i);
      req_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mvalid[i] = 1'b0; mdirty[i] = 1'b0;
      end
      mhits = 0; mmisses = 0;

      // Cold refetch, three hits, one conflict miss
      access(1'b0, 32'h100, 32'd0, 4'h0);
      access(1'b0, 32'h100, 32'd0, 4'h0);
      access(1'b0, 32'h104, 32'd0, 4'h0);
      access(1'b0, 32'h108, 32'd0, 4'h0);
      access(1'b0, 32'h900, 32'd0, 4'h0);
      @(negedge clk_i);
      req_i = 1'b0;
      #1;
      check_stats();

      // Random traffic with random ack latency (including back-to-back)
      rand_mode = 1;
      for (int n = 0; n < 400; n++) begin
         a = {22'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 2'b00};
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk_i);
            req_i = 1'b0;
         end
         access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
      end
      @(negedge clk_i);
      req_i = 1'b0;
      #1;
      check_stats();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
